// File: rtl/fp_mult_pkg.sv
// Shared types, constants and the behavioural reference multiply for fp_mult_top.
// Combinational only; the function is evaluated inside the top's single register stage.
package fp_mult_pkg;

    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } round_values;

    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_NAN     = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [30:0] MAXNORM = 31'h7F7FFFFF;
    localparam logic [30:0] MINNORM = 31'h00800000;

    function automatic logic [31:0] fp_mult_func(
        input logic [31:0] a,
        input logic [31:0] b,
        input round_values round
    );
        logic              sign;
        logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic              g, s, inc, ovf_max, unf_min;
        logic [47:0]       prod;
        logic [45:0]       norm;
        logic [23:0]       mant;
        logic signed [9:0] ex;
        logic [31:0]       res;

        sign   = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        ex   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - $signed(10'(BIAS));
        if (prod[47]) begin
            norm = prod[46:1];
            ex   = ex + 10'sd1;
        end else begin
            norm = prod[45:0];
        end

        g = norm[22];
        s = |norm[21:0];
        case (round)
            IEEE_near: inc = g & (s | norm[23]);
            IEEE_zero: inc = 1'b0;
            IEEE_pinf: inc = ~sign & (g | s);
            IEEE_ninf: inc = sign & (g | s);
            near_up:   inc = g & (s | ~sign);
            away_zero: inc = g | s;
            default:   inc = 1'b0;
        endcase

        // On carry-out the low 23 bits are already zero, only the exponent moves.
        mant = {1'b0, norm[45:23]} + {23'd0, inc};
        if (mant[23])
            ex = ex + 10'sd1;

        ovf_max = (round == IEEE_zero) || ((round == IEEE_pinf) && sign) ||
                  ((round == IEEE_ninf) && !sign);
        unf_min = (round == away_zero) || ((round == IEEE_pinf) && !sign) ||
                  ((round == IEEE_ninf) && sign);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res = QNAN;
        else if (a_inf || b_inf)
            res = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            res = {sign, 31'd0};
        else if (ex > 10'sd254)
            res = ovf_max ? {sign, MAXNORM} : {sign, 8'hFF, 23'd0};
        else if (ex < 10'sd1)
            res = unf_min ? {sign, MINNORM} : {sign, 31'd0};
        else
            res = {sign, ex[7:0], mant[22:0]};
        return res;
    endfunction

endpackage

// File: rtl/fp_round.sv
// Mantissa rounding increment for a compile-time rounding mode.
// Purely combinational; no flow control.
module fp_round
    import fp_mult_pkg::*;
#(
    parameter round_values round = IEEE_near
) (
    input  logic [22:0] i_mant,
    input  logic        i_sign,
    input  logic        i_guard,
    input  logic        i_sticky,
    output logic [22:0] o_mant,
    output logic        o_carry
);

    logic w_inexact;
    logic w_inc;

    assign w_inexact = i_guard | i_sticky;

    always_comb begin
        w_inc = 1'b0;
        case (round)
            IEEE_near: w_inc = i_guard & (i_sticky | i_mant[0]);
            IEEE_zero: w_inc = 1'b0;
            IEEE_pinf: w_inc = ~i_sign & w_inexact;
            IEEE_ninf: w_inc = i_sign & w_inexact;
            near_up:   w_inc = i_guard & (i_sticky | ~i_sign);
            away_zero: w_inc = w_inexact;
            default:   w_inc = 1'b0;
        endcase
    end

    assign {o_carry, o_mant} = {1'b0, i_mant} + {23'd0, w_inc};

endmodule

// File: rtl/fp_mult_top.sv
// IEEE-754 single multiply with structural datapath plus a behavioural twin for self-check.
// Operands registered on edge N, all outputs on edge N+1; one result per cycle, no backpressure.
module fp_mult_top
    import fp_mult_pkg::*;
#(
    parameter round_values round = IEEE_near
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] z,
    output logic [7:0]  status,
    output logic [31:0] z_function_out,
    output logic        sticky,
    output logic        guard
);

    logic [31:0] r_a, r_b;
    logic [31:0] r_z, r_zf;
    logic [7:0]  r_status;
    logic        r_guard, r_sticky;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= a;
            r_b <= b;
        end
    end

    logic w_sign;
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic w_nan_case, w_inf_case, w_zero_case;

    assign w_sign   = r_a[31] ^ r_b[31];
    assign w_a_zero = (r_a[30:23] == 8'd0);
    assign w_b_zero = (r_b[30:23] == 8'd0);
    assign w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);

    assign w_nan_case  = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
    assign w_inf_case  = w_a_inf || w_b_inf;
    assign w_zero_case = w_a_zero || w_b_zero;

    logic [47:0]       w_prod;
    logic [45:0]       w_norm;
    logic signed [9:0] w_exp_raw, w_exp_norm, w_exp_fin;
    logic [22:0]       w_frac, w_frac_rnd;
    logic              w_guard, w_sticky, w_carry;

    assign w_prod     = {24'd0, 1'b1, r_a[22:0]} * {24'd0, 1'b1, r_b[22:0]};
    assign w_exp_raw  = $signed({2'b00, r_a[30:23]}) + $signed({2'b00, r_b[30:23]})
                      - $signed(10'(BIAS));
    // A product in [2,4) drops its LSB and bumps the exponent.
    assign w_norm     = w_prod[47] ? w_prod[46:1] : w_prod[45:0];
    assign w_exp_norm = w_exp_raw + (w_prod[47] ? 10'sd1 : 10'sd0);

    assign w_frac   = w_norm[45:23];
    assign w_guard  = w_norm[22];
    assign w_sticky = |w_norm[21:0];

    fp_round #(
        .round (round)
    ) u_round (
        .i_mant   (w_frac),
        .i_sign   (w_sign),
        .i_guard  (w_guard),
        .i_sticky (w_sticky),
        .o_mant   (w_frac_rnd),
        .o_carry  (w_carry)
    );

    assign w_exp_fin = w_exp_norm + (w_carry ? 10'sd1 : 10'sd0);

    logic w_ovf_max, w_unf_min;

    assign w_ovf_max = (round == IEEE_zero) || ((round == IEEE_pinf) && w_sign) ||
                       ((round == IEEE_ninf) && !w_sign);
    assign w_unf_min = (round == away_zero) || ((round == IEEE_pinf) && !w_sign) ||
                       ((round == IEEE_ninf) && w_sign);

    logic [31:0] w_z;
    logic [7:0]  w_status;
    logic        w_g_out, w_s_out;

    always_comb begin
        w_z      = {w_sign, w_exp_fin[7:0], w_frac_rnd};
        w_status = 8'd0;
        w_g_out  = w_guard;
        w_s_out  = w_sticky;
        w_status[ST_INEXACT] = w_guard | w_sticky;
        if (w_nan_case) begin
            w_z              = QNAN;
            w_status         = 8'd0;
            w_status[ST_NAN] = 1'b1;
            w_g_out          = 1'b0;
            w_s_out          = 1'b0;
        end else if (w_inf_case) begin
            w_z              = {w_sign, 8'hFF, 23'd0};
            w_status         = 8'd0;
            w_status[ST_INF] = 1'b1;
            w_g_out          = 1'b0;
            w_s_out          = 1'b0;
        end else if (w_zero_case) begin
            w_z               = {w_sign, 31'd0};
            w_status          = 8'd0;
            w_status[ST_ZERO] = 1'b1;
            w_g_out           = 1'b0;
            w_s_out           = 1'b0;
        end else if (w_exp_fin > 10'sd254) begin
            w_status[ST_HUGE]    = 1'b1;
            w_status[ST_INEXACT] = 1'b1;
            if (w_ovf_max) begin
                w_z = {w_sign, MAXNORM};
            end else begin
                w_z              = {w_sign, 8'hFF, 23'd0};
                w_status[ST_INF] = 1'b1;
            end
        end else if (w_exp_fin < 10'sd1) begin
            w_status[ST_TINY]    = 1'b1;
            w_status[ST_INEXACT] = 1'b1;
            if (w_unf_min) begin
                w_z = {w_sign, MINNORM};
            end else begin
                w_z               = {w_sign, 31'd0};
                w_status[ST_ZERO] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_z      <= '0;
            r_zf     <= '0;
            r_status <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_z      <= w_z;
            r_zf     <= fp_mult_func(r_a, r_b, round);
            r_status <= w_status;
            r_guard  <= w_g_out;
            r_sticky <= w_s_out;
        end
    end

    assign z              = r_z;
    assign z_function_out = r_zf;
    assign status         = r_status;
    assign guard          = r_guard;
    assign sticky         = r_sticky;

endmodule

// File: tb/tb_fp_mult_top.sv
// Bench for fp_mult_top: one instance per rounding mode, hand vectors plus a random stream
// checked against an exact integer model of the multiply.
module tb_fp_mult_top;
    import fp_mult_pkg::*;

    localparam int NMODE = 6;
    localparam int NRAND = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic [31:0] z_o  [NMODE];
    logic [31:0] zf_o [NMODE];
    logic [7:0]  st_o [NMODE];
    logic        g_o  [NMODE];
    logic        s_o  [NMODE];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NMODE; gi++) begin : g_dut
        fp_mult_top #(
            .round (round_values'(3'(gi)))
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .a              (a),
            .b              (b),
            .z              (z_o[gi]),
            .status         (st_o[gi]),
            .z_function_out (zf_o[gi]),
            .sticky         (s_o[gi]),
            .guard          (g_o[gi])
        );
    end

    typedef struct {
        logic [31:0] z;
        logic [7:0]  st;
        logic        g;
        logic        s;
    } res_t;

    typedef struct {
        int          mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [7:0]  st;
        logic        g;
        logic        s;
    } vec_t;

    // Exact model: real product as an integer, rounding decided by comparing the
    // discarded remainder with one half ulp.
    function automatic res_t ref_mult(input logic [31:0] x, input logic [31:0] y, input int mode);
        res_t            r;
        int              ex, ey, e, sh;
        bit              sg, xn, yn, xi, yi, xz, yz, inx, gt, eq, up, big;
        longint unsigned p, q, rem, half;
        r.z = 32'd0; r.st = 8'd0; r.g = 1'b0; r.s = 1'b0;
        sg = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);   yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 23'd0);
        yi = (ey == 255) && (y[22:0] == 23'd0);
        xn = (ex == 255) && (x[22:0] != 23'd0);
        yn = (ey == 255) && (y[22:0] != 23'd0);
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            r.z = 32'h7FC00000; r.st = 8'h04; return r;
        end
        if (xi || yi) begin
            r.z = {sg, 8'hFF, 23'd0}; r.st = 8'h02; return r;
        end
        if (xz || yz) begin
            r.z = {sg, 31'd0}; r.st = 8'h01; return r;
        end
        p    = (64'h800000 | 64'(x[22:0])) * (64'h800000 | 64'(y[22:0]));
        sh   = (p >= 64'h0000_8000_0000_0000) ? 24 : 23;
        e    = ex + ey - 127 + (sh - 23);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        r.g  = (rem >= half);
        r.s  = ((rem % half) != 0);
        inx  = (rem != 0);
        gt   = (rem > half);
        eq   = (rem == half);
        case (mode)
            0:       up = gt || (eq && q[0]);
            1:       up = 1'b0;
            2:       up = !sg && inx;
            3:       up = sg && inx;
            4:       up = gt || (eq && !sg);
            default: up = inx;
        endcase
        q = q + (up ? 64'd1 : 64'd0);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e > 254) begin
            big  = (mode == 1) || (mode == 2 && sg) || (mode == 3 && !sg);
            r.st = 8'h30;
            if (big) r.z = {sg, 31'h7F7FFFFF};
            else begin r.z = {sg, 8'hFF, 23'd0}; r.st = 8'h32; end
        end else if (e < 1) begin
            big  = (mode == 5) || (mode == 2 && !sg) || (mode == 3 && sg);
            r.st = 8'h28;
            if (big) r.z = {sg, 31'h00800000};
            else begin r.z = {sg, 31'd0}; r.st = 8'h29; end
        end else begin
            r.z  = {sg, 8'(e), 23'(q)};
            r.st = inx ? 8'h20 : 8'h00;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int m, input logic [31:0] oa, input logic [31:0] ob,
                       input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s mode%0d a=%h b=%h got=%h want=%h", name, m, oa, ob, got, want);
        end
    endtask

    task automatic check_all(input string name, input int m, input logic [31:0] oa,
                             input logic [31:0] ob, input res_t e);
        chk({name, ".z"},      m, oa, ob, z_o[m],  e.z);
        chk({name, ".zfunc"},  m, oa, ob, zf_o[m], e.z);
        chk({name, ".status"}, m, oa, ob, 32'(st_o[m]), 32'(e.st));
        chk({name, ".guard"},  m, oa, ob, 32'(g_o[m]),  32'(e.g));
        chk({name, ".sticky"}, m, oa, ob, 32'(s_o[m]),  32'(e.s));
    endtask

    task automatic check_zero(input string name);
        res_t zr;
        zr.z = 32'd0; zr.st = 8'd0; zr.g = 1'b0; zr.s = 1'b0;
        for (int m = 0; m < NMODE; m++)
            check_all(name, m, a, b, zr);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] mt;
        int          sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom);
            default: e = 8'($urandom_range(20, 235));
        endcase
        mt = 23'($urandom);
        if ($urandom_range(0, 3) == 0) mt = mt & 23'h7F0000;
        if (sel == 1 && $urandom_range(0, 1) == 0) mt = 23'd0;
        return {1'($urandom), e, mt};
    endfunction

    vec_t        vecs[$];
    logic [31:0] qa[$], qb[$];
    res_t        er;

    initial begin
        // mode: 0 near, 1 zero, 2 pinf, 3 ninf, 4 near_up, 5 away_zero
        vecs = '{
            '{3, 32'h3FC00000, 32'h40000000, 32'h40400000, 8'h00, 1'b0, 1'b0},
            '{3, 32'h3F800001, 32'h3F800001, 32'h3F800002, 8'h20, 1'b0, 1'b1},
            '{2, 32'h3F800001, 32'h3F800001, 32'h3F800003, 8'h20, 1'b0, 1'b1},
            '{3, 32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 8'h30, 1'b0, 1'b0},
            '{0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 8'h32, 1'b0, 1'b0},
            '{3, 32'h00800000, 32'h00800000, 32'h00000000, 8'h29, 1'b0, 1'b0},
            '{3, 32'h80800000, 32'h00800000, 32'h80800000, 8'h28, 1'b0, 1'b0},
            '{5, 32'h00800000, 32'h00800000, 32'h00800000, 8'h28, 1'b0, 1'b0},
            '{0, 32'h80800000, 32'h00800000, 32'h80000000, 8'h29, 1'b0, 1'b0},
            '{0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 8'h04, 1'b0, 1'b0},
            '{0, 32'h7F800000, 32'hBF800000, 32'hFF800000, 8'h02, 1'b0, 1'b0},
            '{0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 8'h04, 1'b0, 1'b0},
            '{0, 32'h00000001, 32'h3F800000, 32'h00000000, 8'h01, 1'b0, 1'b0},
            '{0, 32'h80000000, 32'h3F800000, 32'h80000000, 8'h01, 1'b0, 1'b0},
            '{0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 8'h20, 1'b1, 1'b0},
            '{0, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 8'h20, 1'b1, 1'b0},
            '{4, 32'hBF800001, 32'h3FC00000, 32'hBFC00001, 8'h20, 1'b1, 1'b0},
            '{1, 32'h3F800001, 32'h3FC00000, 32'h3FC00001, 8'h20, 1'b1, 1'b0},
            '{0, 32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 8'h20, 1'b1, 1'b1},
            '{1, 32'h3FFFFFFE, 32'h3F800001, 32'h3FFFFFFF, 8'h20, 1'b1, 1'b1}
        };

        rst = 1'b0;
        a   = 32'd0;
        b   = 32'd0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].a;
            b = vecs[i].b;
            @(negedge clk);
            @(negedge clk);
            er.z = vecs[i].z; er.st = vecs[i].st; er.g = vecs[i].g; er.s = vecs[i].s;
            check_all("vec", vecs[i].mode, vecs[i].a, vecs[i].b, er);
        end

        // Reset in the middle of a stream clears outputs at once and drops in-flight work.
        @(negedge clk);
        a = 32'h3F800001; b = 32'h3F800001;
        @(negedge clk);
        a = 32'h7F000000; b = 32'h7F000000;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_zero("rst_mid");
        a = 32'h3FC00000; b = 32'h40000000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int m = 0; m < NMODE; m++) begin
            chk("post_rst_first.z", m, a, b, z_o[m], 32'd0);
            chk("post_rst_first.zfunc", m, a, b, zf_o[m], 32'd0);
        end
        @(negedge clk);
        for (int m = 0; m < NMODE; m++)
            check_all("post_rst", m, a, b, ref_mult(a, b, m));

        for (int n = 0; n < NRAND; n++) begin
            logic [31:0] na, nb, oa, ob;
            @(negedge clk);
            if (qa.size() == 2) begin
                oa = qa.pop_front();
                ob = qb.pop_front();
                for (int m = 0; m < NMODE; m++)
                    check_all("rand", m, oa, ob, ref_mult(oa, ob, m));
            end
            na = rnd_op();
            nb = rnd_op();
            a  = na;
            b  = nb;
            qa.push_back(na);
            qb.push_back(nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
